// File: rtl/lcd_pixel_sink.sv
// rtl/lcd_pixel_sink.sv - packs PPU pixels into framebuffer bytes via a write FIFO (option: LCD_SINK_PALETTE_EN)
module lcd_pixel_sink #(
  parameter logic [12:0] FB_BASE    = 13'h0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  PX_OUT,
  input  logic        PX_valid,
  input  logic [1:0]  PPU_MODE,
  input  logic [7:0]  BGP,
  output logic        fb_we,
  output logic [12:0] fb_addr,
  output logic [7:0]  fb_wdata,
  input  logic        fb_ready,
  output logic        frame_done,
  output logic        overflow,
  output logic        short_line,
  input  logic        clr_status
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];
  localparam logic [7:0] LINE_PX = 8'd160;
  localparam logic [7:0] LINES   = 8'd144;

  typedef enum logic [1:0] {
    MODE_HBLANK = 2'd0,
    MODE_VBLANK = 2'd1,
    MODE_SCAN   = 2'd2,
    MODE_DRAW   = 2'd3
  } ppu_mode_t;

  ppu_mode_t   mode_q;
  ppu_mode_t   mode_in;
  logic [7:0]  x, y, part;
  logic [7:0]  x_n, y_n, part_n;
  logic [AW:0] count;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [20:0] mem [FIFO_DEPTH];

  logic        capture, hblank_entry, vblank_entry;
  logic [1:0]  shade;
  logic [12:0] line_base, byte_addr;
  logic [7:0]  filled;
  logic        push, push_ok, pop, full, drop, cap_drop, short_set;
  logic [20:0] push_word;

  assign mode_in      = ppu_mode_t'(PPU_MODE);
  assign capture      = PX_valid && (mode_in == MODE_DRAW);
  assign hblank_entry = (mode_in == MODE_HBLANK) && (mode_q != MODE_HBLANK);
  assign vblank_entry = (mode_in == MODE_VBLANK) && (mode_q != MODE_VBLANK);

`ifdef LCD_SINK_PALETTE_EN
  assign shade = BGP[{PX_OUT, 1'b0} +: 2];
`else
  logic unused_bgp;
  assign unused_bgp = ^BGP;
  assign shade      = PX_OUT;
`endif

  // Byte address of the pixel group x currently falls in; 13-bit wrap is intended.
  assign line_base = FB_BASE + {5'd0, y} * 13'd40;
  assign byte_addr = line_base + {7'd0, x[7:2]};
  // Pixel x%4=0 lands in bits [7:6], x%4=3 in bits [1:0].
  assign filled    = part | ({6'd0, shade} << {~x[1:0], 1'b0});

  assign fb_we    = (count != '0);
  assign fb_addr  = mem[rd_ptr][20:8];
  assign fb_wdata = mem[rd_ptr][7:0];
  assign full     = (count == DEPTH_C);
  assign pop      = fb_we && fb_ready;
  assign push_ok  = push && (!full || pop);
  assign drop     = push && full && !pop;

  // Line/pixel bookkeeping: capture, line-end flush and frame restart.
  always_comb begin
    x_n       = x;
    y_n       = y;
    part_n    = part;
    push      = 1'b0;
    push_word = {byte_addr, filled};
    cap_drop  = 1'b0;
    short_set = 1'b0;
    if (vblank_entry) begin
      x_n    = 8'd0;
      y_n    = 8'd0;
      part_n = 8'd0;
    end else if (hblank_entry && (x != 8'd0)) begin
      if (x[1:0] != 2'd0) begin
        push      = 1'b1;
        push_word = {byte_addr, part};
      end
      part_n    = 8'd0;
      short_set = (x < LINE_PX);
      x_n       = 8'd0;
      y_n       = (y < LINES) ? y + 8'd1 : LINES;
    end else if (capture) begin
      if ((x >= LINE_PX) || (y >= LINES)) begin
        cap_drop = 1'b1;
      end else begin
        x_n = x + 8'd1;
        if (x[1:0] == 2'd3) begin
          push   = 1'b1;
          part_n = 8'd0;
        end else begin
          part_n = filled;
        end
      end
    end
  end

  // Position, partial byte and previous-mode registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x          <= 8'd0;
      y          <= 8'd0;
      part       <= 8'd0;
      mode_q     <= MODE_SCAN;
      frame_done <= 1'b0;
    end else begin
      x          <= x_n;
      y          <= y_n;
      part       <= part_n;
      mode_q     <= mode_in;
      frame_done <= vblank_entry;
    end
  end

  // FIFO pointers and occupancy; a full FIFO still accepts a push when it pops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents are meaningless while count is zero.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_word;
  end

  // Sticky status flags; a set event wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow   <= 1'b0;
      short_line <= 1'b0;
    end else begin
      if (cap_drop || drop) overflow <= 1'b1;
      else if (clr_status)  overflow <= 1'b0;
      if (short_set)        short_line <= 1'b1;
      else if (clr_status)  short_line <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lcd_pixel_sink.sv
// tb/tb_lcd_pixel_sink.sv - self-checking bench for lcd_pixel_sink
module tb_lcd_pixel_sink;
  localparam int DEPTH = 4;
  localparam logic [12:0] BASE = 13'h0000;
`ifdef LCD_SINK_PALETTE_EN
  localparam bit PAL = 1'b1;
`else
  localparam bit PAL = 1'b0;
`endif

  logic        clk, rst;
  logic [1:0]  PX_OUT, PPU_MODE;
  logic        PX_valid, fb_ready, clr_status;
  logic [7:0]  BGP;
  logic        fb_we, frame_done, overflow, short_line;
  logic [12:0] fb_addr;
  logic [7:0]  fb_wdata;

  lcd_pixel_sink #(.FB_BASE(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .PX_OUT(PX_OUT), .PX_valid(PX_valid), .PPU_MODE(PPU_MODE),
    .BGP(BGP), .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata), .fb_ready(fb_ready),
    .frame_done(frame_done), .overflow(overflow), .short_line(short_line),
    .clr_status(clr_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: pixels of the current line, line number, pending bytes, flags.
  int          line_q[$];
  int          y_m;
  int          pm;
  logic [20:0] fifo_m[$];
  bit          ovf_m, short_m, fd_m;

  logic [20:0] wlog[$];
  int          fd_cnt;

  always @(negedge clk) begin
    if (rst && fb_we && fb_ready) wlog.push_back({fb_addr, fb_wdata});
    if (frame_done) fd_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  function automatic int shade_of(int p, logic [7:0] bgp);
    int mapped;
    mapped = (int'(bgp) >> (2 * p)) & 3;
    return PAL ? mapped : p;
  endfunction

  // Byte made of up to four pixels starting at line index start, zero-filled.
  function automatic logic [20:0] make_word(int start);
    int b;
    logic [12:0] a;
    b = 0;
    for (int k = 0; k < 4; k++)
      if (start + k < line_q.size()) b += line_q[start + k] << (6 - 2 * k);
    a = 13'(int'(BASE) + y_m * 40 + start / 4);
    return {a, b[7:0]};
  endfunction

  task automatic model_clear();
    line_q.delete();
    fifo_m.delete();
    y_m = 0; pm = 2;
    ovf_m = 0; short_m = 0; fd_m = 0;
  endtask

  // One clock: drive inputs, compare outputs to model, advance model, pass the edge.
  task automatic cyc(input bit v, input int m, input int p, input bit rdy, input bit clr);
    bit emit, oset, sset, fdn;
    logic [20:0] w;
    PX_valid = v; PPU_MODE = m[1:0]; PX_OUT = p[1:0]; fb_ready = rdy; clr_status = clr;
    chk("we", fb_we, fifo_m.size() != 0);
    if (fifo_m.size() != 0) begin
      chk("addr", fb_addr, fifo_m[0][20:8]);
      chk("wdata", fb_wdata, fifo_m[0][7:0]);
    end
    chk("overflow", overflow, ovf_m);
    chk("short_line", short_line, short_m);
    chk("frame_done", frame_done, fd_m);
    emit = 0; oset = 0; sset = 0; fdn = 0; w = '0;
    if (m == 1 && pm != 1) begin
      line_q.delete(); y_m = 0; fdn = 1;
    end else if (m == 0 && pm != 0 && line_q.size() > 0) begin
      if (line_q.size() % 4 != 0) begin emit = 1; w = make_word((line_q.size() / 4) * 4); end
      if (line_q.size() < 160) sset = 1;
      line_q.delete();
      y_m = (y_m < 144) ? y_m + 1 : 144;
    end else if (m == 3 && v) begin
      if (line_q.size() >= 160 || y_m >= 144) oset = 1;
      else begin
        line_q.push_back(shade_of(p, BGP));
        if (line_q.size() % 4 == 0) begin emit = 1; w = make_word(line_q.size() - 4); end
      end
    end
    if (fifo_m.size() != 0 && rdy) void'(fifo_m.pop_front());
    if (emit) begin
      if (fifo_m.size() == DEPTH) oset = 1;
      else fifo_m.push_back(w);
    end
    ovf_m   = oset ? 1'b1 : (clr ? 1'b0 : ovf_m);
    short_m = sset ? 1'b1 : (clr ? 1'b0 : short_m);
    fd_m = fdn;
    pm = m;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    PX_valid = 0; PPU_MODE = 2; PX_OUT = 0; fb_ready = 1; clr_status = 0;
    rst = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1;
  endtask

  typedef struct {
    logic [7:0] bgp;
    int         px[4];
    logic [7:0] exp_pal;
    logic [7:0] exp_raw;
  } vec_t;
  vec_t tbl[6];

  initial begin
    int cnt, n, mode;
    bit v;

    tbl[0] = '{8'hE4, '{3, 2, 1, 0}, 8'hE4, 8'hE4};
    tbl[1] = '{8'h1B, '{3, 2, 1, 0}, 8'h1B, 8'hE4};
    tbl[2] = '{8'hE4, '{0, 1, 2, 3}, 8'h1B, 8'h1B};
    tbl[3] = '{8'h00, '{3, 3, 3, 3}, 8'h00, 8'hFF};
    tbl[4] = '{8'hFF, '{0, 0, 1, 2}, 8'hFF, 8'h06};
    tbl[5] = '{8'hE4, '{2, 1, 3, 0}, 8'h9C, 8'h9C};

    BGP = 8'hE4;
    PX_valid = 0; PPU_MODE = 2; PX_OUT = 0; fb_ready = 1; clr_status = 0;
    rst = 0;
    #12;
    chk("rst_we", fb_we, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_short", short_line, 0);
    chk("rst_frame_done", frame_done, 0);
    do_reset();

    // Table: one byte per record on line 0, written one cycle after its 4th pixel.
    for (int i = 0; i < 6; i++) begin
      BGP = tbl[i].bgp;
      for (int k = 0; k < 4; k++) cyc(1, 3, tbl[i].px[k], 1, 0);
      chk("tbl_we", fb_we, 1);
      chk("tbl_addr", fb_addr, i);
      chk("tbl_wdata", fb_wdata, PAL ? tbl[i].exp_pal : tbl[i].exp_raw);
    end
    repeat (2) cyc(0, 3, 0, 1, 0);

    // Stalled memory: 5 bytes into a 4-entry FIFO.
    do_reset();
    BGP = 8'hE4;
    wlog.delete();
    repeat (20) cyc(1, 3, 1, 0, 0);
    chk("stall_overflow", overflow, 1);
    chk("stall_we", fb_we, 1);
    repeat (6) cyc(0, 3, 0, 1, 0);
    chk("stall_writes", wlog.size(), 4);
    for (int i = 0; i < 4 && i < wlog.size(); i++) begin
      chk("stall_addr", wlog[i][20:8], i);
      chk("stall_data", wlog[i][7:0], 8'h55);
    end

    // Line overrun, set-vs-clear priority, short line on line 2.
    do_reset();
    BGP = 8'hE4;
    wlog.delete();
    repeat (161) cyc(1, 3, $urandom % 4, 1, 0);
    chk("x160_overflow", overflow, 1);
    cyc(1, 3, 2, 1, 1);
    chk("set_beats_clr", overflow, 1);
    cyc(0, 3, 0, 1, 1);
    chk("clr_overflow", overflow, 0);
    cyc(0, 0, 0, 1, 0); cyc(0, 2, 0, 1, 0);
    chk("full_line_not_short", short_line, 0);
    repeat (160) cyc(1, 3, $urandom % 4, 1, 0);
    cyc(0, 0, 0, 1, 0); cyc(0, 2, 0, 1, 0);
    repeat (6) cyc(1, 3, 3, 1, 0);
    cyc(0, 0, 0, 1, 0); cyc(0, 2, 0, 1, 0);
    chk("short_line_set", short_line, 1);
    repeat (4) cyc(1, 3, 0, 1, 0);
    repeat (3) cyc(0, 2, 0, 1, 0);
    n = wlog.size();
    chk("line2_writes", n, 40 + 40 + 2 + 1);
    if (n >= 3) begin
      chk("line2_addr0", wlog[n-3][20:8], 80);
      chk("line2_data0", wlog[n-3][7:0], 8'hFF);
      chk("line2_addr1", wlog[n-2][20:8], 81);
      chk("line2_data1", wlog[n-2][7:0], 8'hF0);
      chk("line3_addr", wlog[n-1][20:8], 120);
    end

    // Asynchronous reset with three bytes buffered.
    do_reset();
    repeat (12) cyc(1, 3, 2, 0, 0);
    chk("pre_rst_we", fb_we, 1);
    #2 rst = 0;
    #1;
    chk("async_rst_we", fb_we, 0);
    do_reset();
    wlog.delete();
    repeat (4) cyc(1, 3, 1, 1, 0);
    repeat (3) cyc(0, 2, 0, 1, 0);
    chk("post_rst_writes", wlog.size(), 1);
    if (wlog.size() > 0) chk("post_rst_addr", wlog[0][20:8], 0);

    // Full frame with random pixel gaps, then V_BLANK.
    do_reset();
    BGP = 8'($urandom);
    wlog.delete();
    fd_cnt = 0;
    for (int ln = 0; ln < 144; ln++) begin
      cnt = 0;
      while (cnt < 160) begin
        v = ($urandom % 4) != 0;
        cyc(v, 3, $urandom % 4, 1, 0);
        if (v) cnt++;
      end
      cyc(0, 0, 0, 1, 0); cyc(0, 0, 0, 1, 0); cyc(0, 2, 0, 1, 0);
    end
    repeat (3) cyc(0, 1, 0, 1, 0);
    repeat (3) cyc(0, 2, 0, 1, 0);
    chk("frame_writes", wlog.size(), 5760);
    if (wlog.size() > 0) chk("frame_last_addr", wlog[wlog.size()-1][20:8], 13'h167F);
    chk("frame_done_cycles", fd_cnt, 1);
    chk("frame_overflow", overflow, 0);
    chk("frame_short", short_line, 0);

    // Random traffic against the model.
    do_reset();
    mode = 3;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom % 8 == 0) mode = $urandom % 4;
      if ($urandom % 32 == 0) BGP = 8'($urandom);
      cyc($urandom % 2, mode, $urandom % 4, ($urandom % 4) != 0, ($urandom % 16) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lcd_pixel_sink.md
LCD_PIXEL_SINK -- requirements
Module: lcd_pixel_sink

Interface
REQ-001 Parameter FB_BASE, default 13'h0000, framebuffer byte base address added to every write address.
REQ-002 Parameter FIFO_DEPTH, default 4, number of write-buffer entries (power of two, 2..16).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset is asynchronous and active-low.
REQ-005 PX_OUT  input  2  pixel colour index from the PPU pixel FIFO.
REQ-006 PX_valid  input  1  PX_OUT is valid this cycle.
REQ-007 PPU_MODE  input  2  PPU mode: 0 H_BLANK, 1 V_BLANK, 2 SCAN, 3 DRAW.
REQ-008 BGP  input  8  palette register; shade for index i is BGP[2i+1:2i].
REQ-009 fb_we  output  1  write request; high whenever the FIFO is non-empty.
REQ-010 fb_addr  output  13  write byte address, taken from the FIFO head.
REQ-011 fb_wdata  output  8  four packed 2-bit shades, taken from the FIFO head.
REQ-012 fb_ready  input  1  memory accepts the write; the FIFO pops when fb_we && fb_ready.
REQ-013 frame_done  output  1  one-cycle pulse on V_BLANK entry.
REQ-014 overflow  output  1  sticky flag: a pixel or byte was dropped.
REQ-015 short_line  output  1  sticky flag: a line ended with fewer than 160 pixels.
REQ-016 clr_status  input  1  a one-cycle pulse clears overflow and short_line.

Function
REQ-017 A pixel SHALL be captured on a cycle with PX_valid=1 and PPU_MODE=3; PX_valid is ignored in all other modes.
REQ-018 Each captured pixel SHALL be packed MSB-first: x%4=0 goes to bits [7:6] and x%4=3 goes to bits [1:0]; x SHALL then increment.
REQ-019 On capture of the pixel with x%4=3, the completed byte SHALL be pushed to the FIFO at that same edge, with address FB_BASE + y*40 + x/4, computed in 13 bits with wrap-around.
REQ-020 Write latency SHALL be one cycle: fb_we is asserted the cycle after the capture edge of the 4th pixel when the FIFO was empty.
REQ-021 Captures at x≥160, or at y≥144, SHALL be dropped and SHALL set overflow.
REQ-022 A push into a full FIFO SHALL drop the byte and set overflow, except that a push and a pop in the same cycle when full SHALL both succeed.
REQ-023 H_BLANK entry (mode changes to 0) with x>0 SHALL do the following:
- flush any partial byte, with unfilled positions set to 00;
- set short_line if x<160;
- clear x to 0;
- increment y, saturating at 144.
REQ-024 H_BLANK entry with x=0 SHALL leave y unchanged.
REQ-025 V_BLANK entry (mode changes to 1) SHALL pulse frame_done for one cycle, clear x and y to 0, and discard any partial byte without setting flags; the FIFO contents are retained.
REQ-026 A set event and clr_status in the same cycle SHALL leave the flag set.
REQ-027 Mode-change detection SHALL compare PPU_MODE against a one-cycle registered copy, whose reset value is 2.

Reset
REQ-028 Asserting rst SHALL immediately do the following, regardless of the clock:
- empty the FIFO;
- clear x, y, the partial byte, frame_done, overflow and short_line;
- force fb_we to 0.
REQ-029 Reset asserted mid-line SHALL discard buffered bytes with no write issued; after release, capture SHALL start at x=0, y=0.

Configuration
REQ-030 Macro LCD_SINK_PALETTE_EN, when defined, SHALL pack the mapped shade BGP[2*PX_OUT+1:2*PX_OUT].
REQ-031 When LCD_SINK_PALETTE_EN is undefined, the block SHALL pack the raw PX_OUT and ignore BGP.

Verification
REQ-032 Palette enabled, BGP=8'hE4, fb_ready=1, pixels 3,2,1,0 at y=0 -> one write with fb_addr=0x0000 and fb_wdata=8'hE4, one cycle after the 4th pixel.
REQ-033 Palette enabled, BGP=8'h1B, same pixels -> fb_wdata=8'h1B; with the macro undefined -> fb_wdata=8'hE4.
REQ-034 fb_ready=0, 20 pixels of index 1 (5 bytes), FIFO_DEPTH=4 -> overflow=1 and 4 bytes retained; then fb_ready=1 -> 4 writes at addresses 0..3.
REQ-035 Line 2 carries 6 pixels of index 3 and then H_BLANK, palette off -> bytes 8'hFF at addr 80 and 8'hF0 at addr 81; short_line=1; y=3.
REQ-036 Full frame of 144×160 pixels, then V_BLANK -> 5760 writes with last fb_addr=0x167F, frame_done high for exactly 1 cycle, and overflow=0.
REQ-037 rst asserted while the FIFO holds 3 bytes -> fb_we=0 immediately; after release the first write goes to addr 0.
